// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-rate divider, horizontal/vertical
// counters and registered sync / blanking / frame strobes. Every output is
// registered in the same clock as the counters, so x, y and all decodes are
// mutually consistent in any cycle.
module vga_sync_gen #(
   parameter int DIV    = 4,
   parameter int H_VIS  = 640,
   parameter int H_FP   = 16,
   parameter int H_SYNC = 96,
   parameter int H_BP   = 48,
   parameter int V_VIS  = 480,
   parameter int V_FP   = 10,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 33
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       p_tick,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       frame_start
);

   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);

   // Decode bounds are 11 bits so a sync edge landing exactly on 1024 still
   // compares correctly against the 10-bit counters.
   localparam logic [10:0] H_VIS_W = 11'(H_VIS);
   localparam logic [10:0] HS_BEG  = 11'(H_VIS + H_FP);
   localparam logic [10:0] HS_END  = 11'(H_VIS + H_FP + H_SYNC);
   localparam logic [10:0] V_VIS_W = 11'(V_VIS);
   localparam logic [10:0] VS_BEG  = 11'(V_VIS + V_FP);
   localparam logic [10:0] VS_END  = 11'(V_VIS + V_FP + V_SYNC);

   logic [DW-1:0] div_q, div_d;
   logic          p_tick_q, p_tick_d;
   logic [9:0]    x_q, x_d;
   logic [9:0]    y_q, y_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          video_on_q, video_on_d;
   logic          frame_start_q, frame_start_d;
   logic          tick;

   // Next-state: divider always runs; counters and decodes move only on the
   // tick, with decodes taken from the new counter values.
   always_comb begin
      tick          = (div_q == DIV_LAST);
      div_d         = div_q + DW'(1);
      p_tick_d      = tick;
      x_d           = x_q;
      y_d           = y_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      video_on_d    = video_on_q;
      frame_start_d = 1'b0;
      if (tick) begin
         div_d = '0;
         if (x_q == H_LAST) begin
            x_d = '0;
            y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
         end else begin
            x_d = x_q + 10'd1;
         end
         hsync_d       = !(({1'b0, x_d} >= HS_BEG) && ({1'b0, x_d} < HS_END));
         vsync_d       = !(({1'b0, y_d} >= VS_BEG) && ({1'b0, y_d} < VS_END));
         video_on_d    = ({1'b0, x_d} < H_VIS_W) && ({1'b0, y_d} < V_VIS_W);
         frame_start_d = (x_d == 10'd0) && (y_d == 10'd0);
      end
   end

   // State registers; reset parks the raster on the last pixel so the first
   // tick after release lands on (0,0) and raises frame_start.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_q         <= '0;
         p_tick_q      <= 1'b0;
         x_q           <= H_LAST;
         y_q           <= V_LAST;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         video_on_q    <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         div_q         <= div_d;
         p_tick_q      <= p_tick_d;
         x_q           <= x_d;
         y_q           <= y_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         video_on_q    <= video_on_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign p_tick      = p_tick_q;
   assign x           = x_q;
   assign y           = y_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign video_on    = video_on_q;
   assign frame_start = frame_start_q;

endmodule
